// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer producing the 22-bit ALU_TOP control word.
// Optional overflow trap state is built only when OVFL_TRAP_EN is defined.
module multicycle_ctrl_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode_in,
  input  logic [5:0]       funct_in,
  input  logic             mem_ready,
  input  logic             ovfl,
  output logic [21:0]      ctrl_out,
  output logic [3:0]       state_dbg,
  output logic             retire,
  output logic             illegal,
  output logic             exc,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC   = 4'd2,
    MEMRD  = 4'd3,
    MEMWR  = 4'd4,
    WB     = 4'd5,
    BRANCH = 4'd6,
    JUMP   = 4'd7,
    TRAP   = 4'd8
  } state_e;

  typedef struct packed {
    logic [1:0] pcsrc;
    logic [1:0] wbsel;
    logic       regwrite;
    logic       memwrite;
    logic       memread;
    logic       irwrite;
    logic       branch;
    logic       pcwrite;
    logic [1:0] shiftfn;
    logic [1:0] logicfn;
    logic [1:0] alusrcx;
    logic [1:0] alusrcy;
    logic       brne;
    logic       addsub;
    logic [1:0] fntype;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] FT_ARITH = 2'b00;
  localparam logic [1:0] FT_LOGIC = 2'b01;
  localparam logic [1:0] FT_SHIFT = 2'b10;
  localparam logic [1:0] FT_SLT   = 2'b11;
  localparam logic [1:0] SY_Y     = 2'b01;
  localparam logic [1:0] SY_IMM   = 2'b10;
  localparam logic [1:0] SX_PC    = 2'b01;
  localparam logic [1:0] PC_BR    = 2'b01;
  localparam logic [1:0] PC_JMP   = 2'b10;

  state_e           state_q, state_d;
  logic [5:0]       irOp_q, irFunct_q;
  logic [CNT_W-1:0] instrCnt_q;

  logic       isLegal, isRType, isBranch, isJump, isLoad, isStore, canOvfl;
  logic [1:0] exFnType, exLogicFn, exShiftFn;
  logic       exAddSub;
  logic       trapTaken;
  logic       irLoad, retireC, illegalC, excC;
  ctrl_t      ctrl;

  // Instruction class and EXEC-cycle ALU function, decoded from the latched IR
  always_comb begin
    isLegal   = 1'b0;
    isRType   = 1'b0;
    isBranch  = 1'b0;
    isJump    = 1'b0;
    isLoad    = 1'b0;
    isStore   = 1'b0;
    canOvfl   = 1'b0;
    exFnType  = FT_ARITH;
    exAddSub  = 1'b0;
    exLogicFn = 2'b00;
    exShiftFn = 2'b00;
    unique case (irOp_q)
      OP_RTYPE: begin
        isRType = 1'b1;
        isLegal = 1'b1;
        unique case (irFunct_q)
          FN_ADD: canOvfl = 1'b1;
          FN_SUB: begin exAddSub = 1'b1; canOvfl = 1'b1; end
          FN_AND: exFnType = FT_LOGIC;
          FN_OR:  begin exFnType = FT_LOGIC; exLogicFn = 2'b01; end
          FN_XOR: begin exFnType = FT_LOGIC; exLogicFn = 2'b10; end
          FN_NOR: begin exFnType = FT_LOGIC; exLogicFn = 2'b11; end
          FN_SLL: exFnType = FT_SHIFT;
          FN_SRL: begin exFnType = FT_SHIFT; exShiftFn = 2'b01; end
          FN_SRA: begin exFnType = FT_SHIFT; exShiftFn = 2'b10; end
          // slt compares by subtracting y from x
          FN_SLT: begin exFnType = FT_SLT; exAddSub = 1'b1; end
          default: isLegal = 1'b0;
        endcase
      end
      OP_ADDI: begin isLegal = 1'b1; canOvfl = 1'b1; end
      OP_ANDI: begin isLegal = 1'b1; exFnType = FT_LOGIC; end
      OP_ORI:  begin isLegal = 1'b1; exFnType = FT_LOGIC; exLogicFn = 2'b01; end
      OP_LW:   begin isLegal = 1'b1; isLoad = 1'b1; end
      OP_SW:   begin isLegal = 1'b1; isStore = 1'b1; end
      OP_BEQ, OP_BNE: begin isLegal = 1'b1; isBranch = 1'b1; end
      OP_J:    begin isLegal = 1'b1; isJump = 1'b1; end
      default: isLegal = 1'b0;
    endcase
  end

`ifdef OVFL_TRAP_EN
  assign trapTaken = canOvfl & ovfl;
`else
  logic unusedOvfl;
  assign trapTaken  = 1'b0;
  assign unusedOvfl = ovfl ^ canOvfl;
`endif

  always_comb begin
    state_d  = state_q;
    ctrl     = '0;
    irLoad   = 1'b0;
    retireC  = 1'b0;
    illegalC = 1'b0;
    excC     = 1'b0;
    unique case (state_q)
      FETCH: begin
        ctrl.memread = 1'b1;
        ctrl.alusrcx = SX_PC;
        if (mem_ready) begin
          ctrl.pcwrite = 1'b1;
          ctrl.irwrite = 1'b1;
          irLoad       = 1'b1;
          state_d      = DECODE;
        end
      end
      DECODE: begin
        ctrl.alusrcx = SX_PC;
        ctrl.alusrcy = SY_IMM;
        if (!isLegal) begin
          illegalC = 1'b1;
          state_d  = FETCH;
        end else if (isBranch) begin
          state_d = BRANCH;
        end else if (isJump) begin
          state_d = JUMP;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        ctrl.alusrcy = isRType ? SY_Y : SY_IMM;
        ctrl.fntype  = exFnType;
        ctrl.addsub  = exAddSub;
        ctrl.logicfn = exLogicFn;
        ctrl.shiftfn = exShiftFn;
        if (trapTaken)    state_d = TRAP;
        else if (isLoad)  state_d = MEMRD;
        else if (isStore) state_d = MEMWR;
        else              state_d = WB;
      end
      MEMRD: begin
        ctrl.memread = 1'b1;
        if (mem_ready) state_d = WB;
      end
      MEMWR: begin
        ctrl.memwrite = 1'b1;
        if (mem_ready) begin
          retireC = 1'b1;
          state_d = FETCH;
        end
      end
      WB: begin
        ctrl.regwrite = 1'b1;
        ctrl.wbsel    = isLoad ? 2'b01 : 2'b00;
        retireC       = 1'b1;
        state_d       = FETCH;
      end
      BRANCH: begin
        ctrl.alusrcy = SY_Y;
        ctrl.addsub  = 1'b1;
        ctrl.branch  = 1'b1;
        ctrl.brne    = (irOp_q == OP_BNE);
        ctrl.pcsrc   = PC_BR;
        retireC      = 1'b1;
        state_d      = FETCH;
      end
      JUMP: begin
        ctrl.pcwrite = 1'b1;
        ctrl.pcsrc   = PC_JMP;
        retireC      = 1'b1;
        state_d      = FETCH;
      end
      TRAP: begin
        excC    = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      irOp_q     <= '0;
      irFunct_q  <= '0;
      instrCnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (irLoad) begin
        irOp_q    <= opcode_in;
        irFunct_q <= funct_in;
      end
      if (retireC) instrCnt_q <= instrCnt_q + CNT_W'(1);
    end
  end

  // Reset suppresses every strobe so an interrupted instruction issues no partial write
  assign ctrl_out  = reset ? 22'd0 : ctrl;
  assign retire    = retireC & ~reset;
  assign illegal   = illegalC & ~reset;
  assign exc       = excC & ~reset;
  assign state_dbg = state_q;
  assign instr_cnt = instrCnt_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: vector table, hand-written corner sequences and
// randomized instruction streams checked cycle by cycle against an instruction-level model.
module tb_multicycle_ctrl_fsm;

  localparam int CNT_W = 32;
`ifdef OVFL_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  // Control-word field weights
  localparam int W_FN = 1, W_ADDSUB = 4, W_BRNE = 8, W_SRCY = 16, W_SRCX = 64, W_LFN = 256;
  localparam int W_SFN = 1024, W_PCW = 4096, W_BR = 8192, W_IRW = 16384, W_MRD = 32768;
  localparam int W_MWR = 65536, W_RW = 131072, W_WBSEL = 262144, W_PCSRC = 1048576;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       opcode_in, funct_in;
  logic             mem_ready, ovfl;
  logic [21:0]      ctrl_out;
  logic [3:0]       state_dbg;
  logic             retire, illegal, exc;
  logic [CNT_W-1:0] instr_cnt;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode_in(opcode_in), .funct_in(funct_in),
    .mem_ready(mem_ready), .ovfl(ovfl), .ctrl_out(ctrl_out), .state_dbg(state_dbg),
    .retire(retire), .illegal(illegal), .exc(exc), .instr_cnt(instr_cnt)
  );

  typedef enum {K_ILL, K_R, K_I, K_LW, K_SW, K_BR, K_J} kind_e;

  typedef struct {
    logic [3:0]  st;
    logic [21:0] ctrl;
    bit          ret, ill, ex;
    bit          mr, ov, latch;
  } cyc_t;

  typedef struct {
    string      name;
    logic [5:0] op, fn;
    int         fw, mw;
    bit         ov;
    int         expCycles, expRet, expIll, expExc;
  } vec_t;

  cyc_t expQ[$];
  vec_t vecs[$];
  int   checks = 0, failures = 0;
  int   cntModel = 0;
  int   doneAt, rets, ills, excs, cycIdx;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic kind_e classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: begin
        case (fn)
          6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h00, 6'h02, 6'h03, 6'h2a: return K_R;
          default: return K_ILL;
        endcase
      end
      6'h08, 6'h0c, 6'h0d: return K_I;
      6'h23: return K_LW;
      6'h2b: return K_SW;
      6'h04, 6'h05: return K_BR;
      6'h02: return K_J;
      default: return K_ILL;
    endcase
  endfunction

  function automatic int execCtrl(input logic [5:0] op, input logic [5:0] fn);
    int v;
    v = 0;
    if (op == 6'h00) begin
      v = 1 * W_SRCY;
      case (fn)
        6'h22: v += W_ADDSUB;
        6'h24: v += 1 * W_FN;
        6'h25: v += 1 * W_FN + 1 * W_LFN;
        6'h26: v += 1 * W_FN + 2 * W_LFN;
        6'h27: v += 1 * W_FN + 3 * W_LFN;
        6'h00: v += 2 * W_FN;
        6'h02: v += 2 * W_FN + 1 * W_SFN;
        6'h03: v += 2 * W_FN + 2 * W_SFN;
        6'h2a: v += 3 * W_FN + W_ADDSUB;
        default: v += 0;
      endcase
    end else begin
      v = 2 * W_SRCY;
      if (op == 6'h0c) v += 1 * W_FN;
      if (op == 6'h0d) v += 1 * W_FN + 1 * W_LFN;
    end
    return v;
  endfunction

  // mrMode/ovMode: 0 or 1 drive that value, 2 drives a random (don't-care) value
  task automatic pushCyc(input int st, input int ctrl, input bit ret, input bit ill, input bit ex,
                         input int mrMode, input int ovMode, input bit latch);
    cyc_t c;
    c.st    = 4'(st);
    c.ctrl  = 22'(ctrl);
    c.ret   = ret;
    c.ill   = ill;
    c.ex    = ex;
    c.mr    = (mrMode == 2) ? 1'($urandom) : 1'(mrMode);
    c.ov    = (ovMode == 2) ? 1'($urandom) : 1'(ovMode);
    c.latch = latch;
    expQ.push_back(c);
  endtask

  task automatic buildModel(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw, input bit ov);
    kind_e k;
    bit    ovCapable;
    k = classify(op, fn);
    ovCapable = (op == 6'h00 && (fn == 6'h20 || fn == 6'h22)) || op == 6'h08;
    expQ.delete();
    repeat (fw) pushCyc(0, W_MRD + W_SRCX, 0, 0, 0, 0, 2, 0);
    pushCyc(0, W_MRD + W_SRCX + W_PCW + W_IRW, 0, 0, 0, 1, 2, 1);
    pushCyc(1, W_SRCX + 2 * W_SRCY, 0, k == K_ILL, 0, 2, 2, 0);
    if (k == K_ILL) return;
    if (k == K_BR) begin
      pushCyc(6, W_SRCY + W_ADDSUB + W_BR + ((op == 6'h05) ? W_BRNE : 0) + 1 * W_PCSRC, 1, 0, 0, 2, 2, 0);
    end else if (k == K_J) begin
      pushCyc(7, W_PCW + 2 * W_PCSRC, 1, 0, 0, 2, 2, 0);
    end else begin
      pushCyc(2, execCtrl(op, fn), 0, 0, 0, 2, int'(ov), 0);
      if (TRAP_ON && ovCapable && ov) begin
        pushCyc(8, 0, 0, 0, 1, 2, 2, 0);
      end else if (k == K_LW) begin
        repeat (mw) pushCyc(3, W_MRD, 0, 0, 0, 0, 2, 0);
        pushCyc(3, W_MRD, 0, 0, 0, 1, 2, 0);
        pushCyc(5, W_RW + 1 * W_WBSEL, 1, 0, 0, 2, 2, 0);
      end else if (k == K_SW) begin
        repeat (mw) pushCyc(4, W_MWR, 0, 0, 0, 0, 2, 0);
        pushCyc(4, W_MWR, 1, 0, 0, 1, 2, 0);
      end else begin
        pushCyc(5, W_RW, 1, 0, 0, 2, 2, 0);
      end
    end
  endtask

  // Drives one cycle (called just after a rising edge) and checks outputs at the falling edge
  task automatic applyStimulus(input cyc_t e, input logic [5:0] op, input logic [5:0] fn);
    mem_ready = e.mr;
    ovfl      = e.ov;
    if (e.latch) begin
      opcode_in = op;
      funct_in  = fn;
    end else begin
      opcode_in = 6'($urandom);
      funct_in  = 6'($urandom);
    end
    @(negedge clk);
    cycIdx++;
    checkOutput("state_dbg", 64'(state_dbg), 64'(e.st));
    checkOutput("ctrl_out", 64'(ctrl_out), 64'(e.ctrl));
    checkOutput("retire", 64'(retire), 64'(e.ret));
    checkOutput("illegal", 64'(illegal), 64'(e.ill));
    checkOutput("exc", 64'(exc), 64'(e.ex));
    checkOutput("instr_cnt", 64'(instr_cnt), 64'(cntModel));
    if (retire) rets++;
    if (illegal) ills++;
    if (exc) excs++;
    if ((retire || illegal || exc) && doneAt < 0) doneAt = cycIdx;
    if (e.ret) cntModel++;
    @(posedge clk);
    #1;
  endtask

  task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw, input bit ov);
    buildModel(op, fn, fw, mw, ov);
    doneAt = -1; rets = 0; ills = 0; excs = 0; cycIdx = 0;
    foreach (expQ[i]) applyStimulus(expQ[i], op, fn);
  endtask

  task automatic doReset(input int n);
    reset     = 1'b1;
    mem_ready = 1'b1;
    ovfl      = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("reset_ctrl", 64'(ctrl_out), 64'd0);
      checkOutput("reset_pulses", 64'({retire, illegal, exc}), 64'd0);
      checkOutput("reset_state", 64'(state_dbg), 64'd0);
      checkOutput("reset_cnt", 64'(instr_cnt), 64'd0);
      @(posedge clk);
      #1;
    end
    reset    = 1'b0;
    cntModel = 0;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [5:0] legalOps[9];
    logic [5:0] legalFns[10];
    logic [5:0] op, fn;
    int         tgt;
    legalOps = '{6'h00, 6'h08, 6'h0c, 6'h0d, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02};
    legalFns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h00, 6'h02, 6'h03, 6'h2a};

    vecs.push_back('{"add",     6'h00, 6'h20, 0, 0, 1'b0, 4, 1, 0, 0});
    vecs.push_back('{"sub_fw1", 6'h00, 6'h22, 1, 0, 1'b0, 5, 1, 0, 0});
    vecs.push_back('{"and",     6'h00, 6'h24, 0, 0, 1'b0, 4, 1, 0, 0});
    vecs.push_back('{"or",      6'h00, 6'h25, 0, 0, 1'b0, 4, 1, 0, 0});
    vecs.push_back('{"xor",     6'h00, 6'h26, 0, 0, 1'b0, 4, 1, 0, 0});
    vecs.push_back('{"nor",     6'h00, 6'h27, 0, 0, 1'b0, 4, 1, 0, 0});
    vecs.push_back('{"sll",     6'h00, 6'h00, 0, 0, 1'b0, 4, 1, 0, 0});
    vecs.push_back('{"srl",     6'h00, 6'h02, 0, 0, 1'b0, 4, 1, 0, 0});
    vecs.push_back('{"sra",     6'h00, 6'h03, 0, 0, 1'b0, 4, 1, 0, 0});
    vecs.push_back('{"slt",     6'h00, 6'h2a, 0, 0, 1'b0, 4, 1, 0, 0});
    vecs.push_back('{"addi",    6'h08, 6'h15, 0, 0, 1'b0, 4, 1, 0, 0});
    vecs.push_back('{"andi",    6'h0c, 6'h3f, 0, 0, 1'b0, 4, 1, 0, 0});
    vecs.push_back('{"ori",     6'h0d, 6'h01, 0, 0, 1'b0, 4, 1, 0, 0});
    vecs.push_back('{"lw_mw3",  6'h23, 6'h00, 0, 3, 1'b0, 8, 1, 0, 0});
    vecs.push_back('{"lw",      6'h23, 6'h07, 0, 0, 1'b0, 5, 1, 0, 0});
    vecs.push_back('{"sw_mw2",  6'h2b, 6'h00, 0, 2, 1'b0, 6, 1, 0, 0});
    vecs.push_back('{"beq",     6'h04, 6'h00, 0, 0, 1'b0, 3, 1, 0, 0});
    vecs.push_back('{"bne",     6'h05, 6'h00, 0, 0, 1'b0, 3, 1, 0, 0});
    vecs.push_back('{"j",       6'h02, 6'h00, 0, 0, 1'b0, 3, 1, 0, 0});
    vecs.push_back('{"op3f",    6'h3f, 6'h00, 0, 0, 1'b0, 2, 0, 1, 0});
    vecs.push_back('{"rbadfn",  6'h00, 6'h01, 0, 0, 1'b0, 2, 0, 1, 0});
    vecs.push_back('{"add_ovf", 6'h00, 6'h20, 0, 0, 1'b1, 4, TRAP_ON ? 0 : 1, 0, TRAP_ON ? 1 : 0});
    vecs.push_back('{"and_ovf", 6'h00, 6'h24, 0, 0, 1'b1, 4, 1, 0, 0});

    opcode_in = '0;
    funct_in  = '0;
    doReset(2);

    foreach (vecs[i]) begin
      runInstr(vecs[i].op, vecs[i].fn, vecs[i].fw, vecs[i].mw, vecs[i].ov);
      checkOutput({vecs[i].name, "_cycles"}, 64'(doneAt), 64'(vecs[i].expCycles));
      checkOutput({vecs[i].name, "_retires"}, 64'(rets), 64'(vecs[i].expRet));
      checkOutput({vecs[i].name, "_illegals"}, 64'(ills), 64'(vecs[i].expIll));
      checkOutput({vecs[i].name, "_excs"}, 64'(excs), 64'(vecs[i].expExc));
    end

    // Reset arriving in MEMRD of a stalled lw: strobes drop at once, then a clean FETCH
    buildModel(6'h23, 6'h00, 0, 3, 1'b0);
    doneAt = -1; rets = 0; ills = 0; excs = 0; cycIdx = 0;
    tgt = 0;
    while (expQ[tgt].st != 4'd3) tgt++;
    for (int i = 0; i < tgt; i++) applyStimulus(expQ[i], 6'h23, 6'h00);
    reset     = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    checkOutput("midreset_ctrl", 64'(ctrl_out), 64'd0);
    checkOutput("midreset_pulses", 64'({retire, illegal, exc}), 64'd0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    cntModel  = 0;
    mem_ready = 1'b0;
    @(negedge clk);
    checkOutput("postreset_state", 64'(state_dbg), 64'd0);
    checkOutput("postreset_ctrl", 64'(ctrl_out), 64'(W_MRD + W_SRCX));
    checkOutput("postreset_cnt", 64'(instr_cnt), 64'd0);
    @(posedge clk);
    #1;
    runInstr(6'h05, 6'h00, 0, 0, 1'b0);
    checkOutput("bne_after_reset_cycles", 64'(doneAt), 64'd3);

    for (int n = 0; n < 80; n++) begin
      op = ($urandom_range(0, 9) < 8) ? legalOps[$urandom_range(0, 8)] : 6'($urandom);
      fn = ($urandom_range(0, 9) < 8) ? legalFns[$urandom_range(0, 9)] : 6'($urandom);
      runInstr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
